flag_shadow_stack: RTL and testbench
====================================

FLAG_SHADOW_STACK -- requirements
Module: flag_shadow_stack

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of saved flag entries (legal range 2..16).
REQ-002 Parameter CNT_W, default $clog2(DEPTH+1), SHALL set the width of the occupancy count.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 push  input  1  SHALL request saving the live C/Z flags (interrupt entry).
REQ-006 pop  input  1  SHALL request restoring the most recently saved C/Z flags (return from interrupt).
REQ-007 c_in, z_in  input  1 each  SHALL be the live carry/zero flag values to save.
REQ-008 err_clr  input  1  SHALL clear the sticky error flags.
REQ-009 c_rst, z_rst  output  1 each  SHALL be the registered restored flag values.
REQ-010 rst_vld  output  1  SHALL pulse high for one cycle when c_rst/z_rst carry a valid restore.
REQ-011 count  output  CNT_W  SHALL be the number of entries currently held.
REQ-012 full, empty  output  1 each  SHALL indicate count==DEPTH and count==0 (combinational from count).
REQ-013 ovf_err, udf_err  output  1 each  SHALL be sticky overflow/underflow indicators.

Function
REQ-014 Storage SHALL be a LIFO of DEPTH 2-bit entries {C,Z}, addressed by count; top entry is index count-1.
REQ-015 push only, not full: entry[count] <= {c_in,z_in}; count <= count+1; rst_vld stays 0.
REQ-016 push only, full: write dropped, count unchanged, stored entries unchanged, ovf_err <= 1.
REQ-017 pop only, not empty: {c_rst,z_rst} <= entry[count-1]; rst_vld <= 1 in the following cycle (latency 1); count <= count-1.
REQ-018 pop only, empty: count unchanged, c_rst/z_rst hold previous values, rst_vld stays 0, udf_err <= 1.
REQ-019 push and pop same cycle, not empty: restore returns the old top entry; the top entry is overwritten with {c_in,z_in}; count unchanged; rst_vld <= 1; no error.
REQ-020 push and pop same cycle, empty: bypass; {c_rst,z_rst} <= {c_in,z_in}; rst_vld <= 1; count stays 0; no error.
REQ-021 push and pop same cycle, full: handled per REQ-019; ovf_err SHALL NOT set.
REQ-022 Neither push nor pop: all state holds; rst_vld <= 0.
REQ-023 c_rst/z_rst SHALL hold their last restored value between restores.
REQ-024 err_clr SHALL clear ovf_err and udf_err next edge; an error event in the same cycle SHALL win (flag set).
REQ-025 count SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-026 rst_n low SHALL immediately, without waiting for clk, force count=0, c_rst=0, z_rst=0, rst_vld=0, ovf_err=0, udf_err=0; empty=1, full=0.
REQ-027 Entry storage contents need not be reset; entries SHALL NOT be readable until re-pushed.
REQ-028 Reset asserted mid-operation (push/pop active) SHALL discard the operation; first edge after release with push/pop low leaves all outputs at reset values.

Verification
REQ-029 Reset, push {C=1,Z=0} then {0,1}, pop, pop -> rst_vld pulses with {0,1} then {1,0}; count 0,1,2,1,0; empty=1 at end.
REQ-030 DEPTH=4: push 5 times with {1,1},{0,0},{1,0},{0,1},{1,1} -> count=4, full=1, ovf_err=1 after 5th; 4 pops return {0,1},{1,0},{0,0},{1,1}.
REQ-031 Pop while empty -> rst_vld=0, c_rst/z_rst unchanged, udf_err=1; then err_clr -> udf_err=0; err_clr together with empty pop -> udf_err stays 1.
REQ-032 count=2 top {1,0}, push+pop with c_in=0,z_in=1 -> rst_vld=1, {c_rst,z_rst}={1,0}, count=2; next pop returns {0,1}.
REQ-033 Empty, push+pop with c_in=1,z_in=1 -> rst_vld=1, {1,1} restored, count=0, no error flags.
REQ-034 count=3, assert rst_n low between edges -> count=0, rst_vld=0, errors=0 immediately, before next clk edge.

Source files
------------

// File: rtl/flag_shadow_stack.sv
// LIFO that saves C/Z flags on interrupt entry and restores them on return.
// A push and pop in the same cycle swap the top entry, or bypass it when the stack is empty.
module flag_shadow_stack #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             c_in,
    input  logic             z_in,
    input  logic             err_clr,
    output logic             c_rst,
    output logic             z_rst,
    output logic             rst_vld,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf_err,
    output logic             udf_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;
    logic          do_push;
    logic          do_pop;
    logic          swap;
    logic          bypass;
    logic          ovf_ev;
    logic          udf_ev;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        do_push = push & ~pop & ~full;
        do_pop  = pop & ~push & ~empty;
        swap    = push & pop & ~empty;
        bypass  = push & pop & empty;
        ovf_ev  = push & ~pop & full;
        udf_ev  = pop & ~push & empty;
        top_idx = AW'(count - CNT_W'(1));
        // A swap overwrites the current top; a plain push writes one above it.
        wr_idx  = swap ? top_idx : AW'(count);
    end

    always_ff @(posedge clk) begin
        if (do_push || swap) begin
            mem[wr_idx] <= {c_in, z_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            c_rst   <= 1'b0;
            z_rst   <= 1'b0;
            rst_vld <= 1'b0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (do_push) begin
                count <= count + CNT_W'(1);
            end else if (do_pop) begin
                count <= count - CNT_W'(1);
            end

            if (do_pop || swap) begin
                {c_rst, z_rst} <= mem[top_idx];
            end else if (bypass) begin
                {c_rst, z_rst} <= {c_in, z_in};
            end

            rst_vld <= do_pop | swap | bypass;

            if (ovf_ev) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end

            if (udf_ev) begin
                udf_err <= 1'b1;
            end else if (err_clr) begin
                udf_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flag_shadow_stack.sv
// Directed-vector bench for flag_shadow_stack (DEPTH=4).
module tb_flag_shadow_stack;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             push;
    logic             pop;
    logic             c_in;
    logic             z_in;
    logic             err_clr;
    logic             c_rst;
    logic             z_rst;
    logic             rst_vld;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             ovf_err;
    logic             udf_err;

    int unsigned n_vec;
    int unsigned n_bad;

    flag_shadow_stack #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .c_in    (c_in),
        .z_in    (z_in),
        .err_clr (err_clr),
        .c_rst   (c_rst),
        .z_rst   (z_rst),
        .rst_vld (rst_vld),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf_err (ovf_err),
        .udf_err (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given controls, then sample 1 time unit after the edge.
    task automatic op(input logic p, input logic q, input logic c, input logic z, input logic e);
        push    = p;
        pop     = q;
        c_in    = c;
        z_in    = z;
        err_clr = e;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
    endtask

    // Checks restore outputs and occupancy together.
    task automatic chk_rst(input string tag, input logic vld, input logic [1:0] cz, input int cnt);
        check({tag, ".vld"}, {7'd0, rst_vld}, {7'd0, vld});
        check({tag, ".cz"}, {6'd0, c_rst, z_rst}, {6'd0, cz});
        check({tag, ".cnt"}, 8'(count), 8'(cnt));
    endtask

    task automatic chk_err(input string tag, input logic ovf, input logic udf);
        check({tag, ".ovf"}, {7'd0, ovf_err}, {7'd0, ovf});
        check({tag, ".udf"}, {7'd0, udf_err}, {7'd0, udf});
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        c_in    = 1'b0;
        z_in    = 1'b0;
        err_clr = 1'b0;

        #2;
        chk_rst("reset", 1'b0, 2'b00, 0);
        chk_err("reset", 1'b0, 1'b0);
        check("reset.empty", {7'd0, empty}, 8'd1);
        check("reset.full", {7'd0, full}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op(0, 0, 0, 0, 0);
        chk_rst("idle0", 1'b0, 2'b00, 0);

        // Basic save / restore ordering
        op(1, 0, 1, 0, 0); chk_rst("b.push1", 1'b0, 2'b00, 1);
        op(1, 0, 0, 1, 0); chk_rst("b.push2", 1'b0, 2'b00, 2);
        op(0, 1, 0, 0, 0); chk_rst("b.pop1", 1'b1, 2'b01, 1);
        op(0, 1, 0, 0, 0); chk_rst("b.pop2", 1'b1, 2'b10, 0);
        check("b.empty", {7'd0, empty}, 8'd1);
        op(0, 0, 1, 1, 0); chk_rst("b.hold", 1'b0, 2'b10, 0);

        // Fill to DEPTH, then overflow
        op(1, 0, 1, 1, 0);
        op(1, 0, 0, 0, 0);
        op(1, 0, 1, 0, 0);
        op(1, 0, 0, 1, 0);
        check("f.cnt4", 8'(count), 8'd4);
        check("f.full", {7'd0, full}, 8'd1);
        chk_err("f.pre", 1'b0, 1'b0);
        op(1, 0, 1, 1, 0); chk_rst("f.ovpush", 1'b0, 2'b10, 4);
        chk_err("f.ovf", 1'b1, 1'b0);
        op(0, 1, 0, 0, 0); chk_rst("f.pop1", 1'b1, 2'b01, 3);
        check("f.notfull", {7'd0, full}, 8'd0);
        op(0, 1, 0, 0, 0); chk_rst("f.pop2", 1'b1, 2'b10, 2);
        op(0, 1, 0, 0, 0); chk_rst("f.pop3", 1'b1, 2'b00, 1);
        op(0, 1, 0, 0, 0); chk_rst("f.pop4", 1'b1, 2'b11, 0);

        // Underflow and sticky-error clearing
        op(0, 1, 0, 0, 0); chk_rst("u.pop", 1'b0, 2'b11, 0);
        chk_err("u.err", 1'b1, 1'b1);
        op(0, 0, 0, 0, 1); chk_err("u.clr", 1'b0, 1'b0);
        op(0, 1, 0, 0, 1); chk_err("u.clrwin", 1'b0, 1'b1);
        op(0, 0, 0, 0, 1); chk_err("u.clr2", 1'b0, 1'b0);

        // Swap at count=2
        op(1, 0, 1, 1, 0);
        op(1, 0, 1, 0, 0);
        op(1, 1, 0, 1, 0); chk_rst("s.swap", 1'b1, 2'b10, 2);
        chk_err("s.err", 1'b0, 1'b0);
        op(0, 1, 0, 0, 0); chk_rst("s.pop1", 1'b1, 2'b01, 1);
        op(0, 1, 0, 0, 0); chk_rst("s.pop2", 1'b1, 2'b11, 0);

        // Bypass when empty
        op(1, 0, 0, 0, 0);
        op(0, 1, 0, 0, 0); chk_rst("y.pre", 1'b1, 2'b00, 0);
        op(1, 1, 1, 1, 0); chk_rst("y.byp", 1'b1, 2'b11, 0);
        chk_err("y.err", 1'b0, 1'b0);

        // Swap while full must not flag overflow
        op(1, 0, 1, 0, 0);
        op(1, 0, 0, 1, 0);
        op(1, 0, 0, 0, 0);
        op(1, 0, 1, 1, 0);
        op(1, 1, 0, 1, 0); chk_rst("w.swap", 1'b1, 2'b11, 4);
        chk_err("w.err", 1'b0, 1'b0);
        op(0, 1, 0, 0, 0); chk_rst("w.pop", 1'b1, 2'b01, 3);

        // Asynchronous reset mid-operation at count=3
        #2;
        push  = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_rst("a.rst", 1'b0, 2'b00, 0);
        chk_err("a.rst", 1'b0, 1'b0);
        check("a.empty", {7'd0, empty}, 8'd1);
        @(negedge clk);
        push  = 1'b0;
        rst_n = 1'b1;
        op(0, 0, 0, 0, 0); chk_rst("a.post", 1'b0, 2'b00, 0);
        chk_err("a.post", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
